// File: rtl/hack_screen_scanout.sv
// Hack screen pixel stage: fetches 16-bit screen words ahead of the beam,
// serialises them LSB-first and drives VGA colour with syncs re-aligned to it.
module hack_screen_scanout #(
    parameter logic [9:0] HOFF       = 10'd64,
    parameter logic [9:0] VOFF       = 10'd112,
    parameter logic [2:0] FG_RGB     = 3'b000,
    parameter logic [2:0] BG_RGB     = 3'b111,
    parameter logic [2:0] BORDER_RGB = 3'b001
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  CounterX,
    input  logic [9:0]  CounterY,
    input  logic        inDisplayArea,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic        mem_rd,
    output logic [12:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  vga_rgb,
    output logic        vga_h_sync,
    output logic        vga_v_sync
);

    logic [10:0] wx;
    logic [10:0] wy;
    logic [10:0] px;
    logic        in_win;
    logic        row_ok;
    logic        fetch_hit;
    logic        load_hit;
    logic [15:0] shift;
    logic [15:0] prefetch;
    logic        prefetch_valid;
    logic        rd_q;
    logic [15:0] load_word;
    logic        cur_bit;
    logic [2:0]  pix_rgb;

    // 11-bit differences: anything left of / above the window wraps to a large value
    assign wx     = {1'b0, CounterX} - {1'b0, HOFF};
    assign wy     = {1'b0, CounterY} - {1'b0, VOFF};
    assign px     = wx + 11'd8;
    assign in_win = (wx < 11'd512) && (wy < 11'd256);
    assign row_ok = (wy < 11'd256);

    assign fetch_hit = pix_en && (px < 11'd512) && (px[3:0] == 4'd0) && row_ok;
    assign load_hit  = pix_en && in_win && (wx[3:0] == 4'd0);

    // A word that was never fetched for this slot shows as background
    assign load_word = prefetch_valid ? prefetch : 16'h0000;
    assign cur_bit   = load_hit ? load_word[0] : shift[0];

    always_comb begin
        pix_rgb = BORDER_RGB;
        if (!inDisplayArea) begin
            pix_rgb = 3'b000;
        end else if (in_win) begin
            pix_rgb = cur_bit ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            mem_rd         <= 1'b0;
            mem_addr       <= 13'd0;
            rd_q           <= 1'b0;
            shift          <= 16'h0000;
            prefetch       <= 16'h0000;
            prefetch_valid <= 1'b0;
            vga_rgb        <= 3'b000;
            vga_h_sync     <= 1'b1;
            vga_v_sync     <= 1'b1;
        end else begin
            mem_rd <= fetch_hit;
            rd_q   <= mem_rd;
            if (fetch_hit) begin
                mem_addr <= {wy[7:0], px[8:4]};
            end
            // RAM data is valid the cycle after mem_rd; capture it on the following edge
            if (rd_q) begin
                prefetch       <= mem_rdata;
                prefetch_valid <= 1'b1;
            end
            if (pix_en) begin
                if (load_hit) begin
                    shift          <= load_word >> 1;
                    prefetch_valid <= 1'b0;
                end else if (in_win) begin
                    shift <= shift >> 1;
                end
                vga_rgb    <= pix_rgb;
                vga_h_sync <= h_sync_in;
                vga_v_sync <= v_sync_in;
            end
        end
    end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout: directed scan lines against a pixel-level
// model of the Hack window, plus hand-computed pixel expectations.
module tb_hack_screen_scanout;

    localparam logic [2:0] FG     = 3'b000;
    localparam logic [2:0] BG     = 3'b111;
    localparam logic [2:0] BORDER = 3'b001;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [9:0]  cx = 10'd0;
    logic [9:0]  cy = 10'd0;
    logic        de = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        mem_rd;
    logic [12:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic [2:0]  vga_rgb;
    logic        vga_h_sync;
    logic        vga_v_sync;

    logic [15:0] ram [8192];

    int compared   = 0;
    int mismatched = 0;
    logic checking = 1'b0;

    logic [2:0]  exp_rgb  = 3'b000;
    logic        exp_hs   = 1'b1;
    logic        exp_vs   = 1'b1;
    logic        exp_rd   = 1'b0;
    logic [12:0] exp_addr = 13'd0;

    logic [15:0] cur_word = 16'h0000;
    int          fetched  = -1;
    int          n_rd     = 0;
    int          first_x  = -1;
    int          cur_x    = 0;
    logic [12:0] last_addr = 13'd0;

    hack_screen_scanout dut (
        .clk50         (clk50),
        .rst           (rst),
        .pix_en        (pix_en),
        .CounterX      (cx),
        .CounterY      (cy),
        .inDisplayArea (de),
        .h_sync_in     (hs),
        .v_sync_in     (vs),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .vga_rgb       (vga_rgb),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) mem_rdata <= ram[mem_addr];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (x=%0d y=%0d)", name, got, want, cx, cy);
        end
    endtask

    always @(negedge clk50) begin
        if (checking) begin
            check("rgb", 16'(vga_rgb), 16'(exp_rgb));
            check("hsync", 16'(vga_h_sync), 16'(exp_hs));
            check("vsync", 16'(vga_v_sync), 16'(exp_vs));
            check("mem_rd", 16'(mem_rd), 16'(exp_rd));
            check("mem_addr", 16'(mem_addr), 16'(exp_addr));
            if (mem_rd === 1'b1) begin
                if (n_rd == 0) first_x = cur_x;
                n_rd++;
                last_addr = mem_addr;
            end
        end
    end

    // One pixel beat: drive counters with pix_en for one cycle, then one idle cycle
    task automatic beat(input int x, input int y);
        int wx, wy, px, fa;
        logic inwin, f, b;
        logic [2:0] r;
        wx = x - 64;
        wy = y - 112;
        px = x - 56;
        fa = 0;
        @(negedge clk50);
        cx = 10'(x);
        cy = 10'(y);
        de = (x < 640) && (y < 480);
        hs = !(x >= 656 && x < 752);
        vs = !(y >= 490 && y < 492);
        pix_en = 1'b1;
        cur_x = x;
        inwin = (wx >= 0) && (wx < 512) && (wy >= 0) && (wy < 256);
        f = (px >= 0) && (px < 512) && (px % 16 == 0) && (wy >= 0) && (wy < 256);
        if (f) begin
            fa = wy * 32 + px / 16;
            fetched = fa;
        end
        if (inwin && (wx % 16 == 0)) begin
            cur_word = (fetched == wy * 32 + wx / 16) ? ram[wy * 32 + wx / 16] : 16'h0000;
            fetched = -1;
        end
        b = inwin ? cur_word[wx % 16] : 1'b0;
        r = !de ? 3'b000 : (inwin ? (b ? FG : BG) : BORDER);
        @(posedge clk50);
        #1;
        pix_en = 1'b0;
        exp_rgb = r;
        exp_hs = hs;
        exp_vs = vs;
        exp_rd = f;
        if (f) exp_addr = 13'(fa);
        @(posedge clk50);
        #1;
        exp_rd = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk50);
        rst = 1'b1;
        pix_en = 1'b0;
        @(posedge clk50);
        #1;
        exp_rgb = 3'b000;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_rd = 1'b0;
        exp_addr = 13'd0;
        cur_word = 16'h0000;
        fetched = -1;
        repeat (n - 1) @(posedge clk50);
        #1;
        check("rst_rgb", 16'(vga_rgb), 16'h0000);
        check("rst_hsync", 16'(vga_h_sync), 16'h0001);
        check("rst_vsync", 16'(vga_v_sync), 16'h0001);
        check("rst_mem_rd", 16'(mem_rd), 16'h0000);
        @(negedge clk50);
        rst = 1'b0;
    endtask

    task automatic sweep(input int y, input int skip_x, input int rst_x);
        for (int x = 0; x < 800; x++) begin
            if (x != skip_x) begin
                beat(x, y);
                if (y == 112 && x == 64) check("px64_fg", 16'(vga_rgb), 16'(FG));
                if (y == 112 && x >= 65 && x <= 79) check("px65_79_bg", 16'(vga_rgb), 16'(BG));
                if (y == 112 && x == 95) check("px95_fg", 16'(vga_rgb), 16'(FG));
                if (y == 114 && x >= 64 && x <= 79) check("miss_bg", 16'(vga_rgb), 16'(BG));
                if (y == 367 && x == 575) check("px575_fg", 16'(vga_rgb), 16'(FG));
                if (y == 367 && x == 576) check("px576_border", 16'(vga_rgb), 16'(BORDER));
                if (y == 10 && x == 10) check("border", 16'(vga_rgb), 16'(BORDER));
                if (y == 10 && x == 700) check("blank", 16'(vga_rgb), 16'h0000);
                if (y == 10 && x == 655) check("hsync_hi", 16'(vga_h_sync), 16'h0001);
                if (y == 10 && x == 656) check("hsync_lo", 16'(vga_h_sync), 16'h0000);
                if (rst_x >= 0 && x == rst_x + 1) check("post_rst_bg", 16'(vga_rgb), 16'(BG));
                if (x == rst_x) do_reset(3);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'((i * 40503) ^ (i >> 3));
        ram[0]    = 16'h0001;
        ram[1]    = 16'h8000;
        ram[63]   = 16'hFFFF;
        ram[64]   = 16'hFFFF;
        ram[8191] = 16'h8000;

        rst = 1'b1;
        repeat (3) @(posedge clk50);
        #1;
        checking = 1'b1;
        check("init_rgb", 16'(vga_rgb), 16'h0000);
        check("init_hsync", 16'(vga_h_sync), 16'h0001);
        check("init_mem_rd", 16'(mem_rd), 16'h0000);
        @(negedge clk50);
        rst = 1'b0;

        n_rd = 0;
        sweep(112, -1, -1);
        check("rd_count", 16'(n_rd), 16'd32);
        check("first_rd_x", 16'(first_x), 16'd56);

        sweep(113, -1, 200);
        sweep(114, 56, -1);
        sweep(10, -1, -1);

        n_rd = 0;
        sweep(367, -1, -1);
        check("rd_count_367", 16'(n_rd), 16'd32);
        check("last_addr", 16'(last_addr), 16'h1FFF);

        n_rd = 0;
        sweep(490, -1, -1);
        beat(800, 490);
        check("rd_count_vblank", 16'(n_rd), 16'd0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
